ctu_clsp_ckseq: RTL and testbench

- CMP-domain clock-enable and reset sequencer. Produces the start-clock, per-cluster clock-enable, global-reset and debug-init levels consumed by the CMP global-interface flop stage.
- On a start request it raises start_clk, ramps the cluster clock enables one slot at a time, holds reset and then releases it.
- On a stop request it tears the sequence down in reverse order.
- All outputs are registered and glitch-free.

---
 rtl/ctu_clsp_ckseq.sv | 183 ++++++++++++++++++
 tb/tb_ctu_clsp_ckseq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ctu_clsp_ckseq.sv
// ctu_clsp_ckseq: CMP clock-enable and reset sequencer.
// Ramps cluster clock enables up on start, holds reset, and tears down in reverse on stop.
module ctu_clsp_ckseq #(
   parameter int NUM_CKEN = 22,
   parameter int GAP_W    = 4,
   parameter int RST_HOLD = 16
) (
   input  logic                cmp_gclk,
   input  logic                cmp_rst,
   input  logic                seq_start,
   input  logic                seq_stop,
   input  logic                dbg_init_req,
   input  logic [NUM_CKEN-1:0] cken_mask,
   input  logic [GAP_W-1:0]    gap_cnt,
   output logic                start_clk_cl,
   output logic [NUM_CKEN-1:0] cken_cg,
   output logic                cmp_grst_cl_l,
   output logic                cmp_dbginit_cl_l,
   output logic                seq_busy,
   output logic                seq_done
);
   localparam int IW = $clog2(NUM_CKEN);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_RAMP  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_DBG   = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;

   logic [2:0]          state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [GAP_W-1:0]    cnt_q, cnt_d, gap_q, gap_d;
   logic [HW-1:0]       hcnt_q, hcnt_d;
   logic [NUM_CKEN-1:0] cken_q, cken_d, mask_q, mask_d;
   logic                start_q, start_d, grst_q, grst_d, dbg_q, dbg_d;
   logic                pend_q, pend_d, busy_q, busy_d, done_q, done_d;
   logic                slot_end, hold_end, last_idx, go_stop;
   logic [IW-1:0]       nidx, pidx;

   assign slot_end = cnt_q == gap_q;
   assign hold_end = hcnt_q == HW'(RST_HOLD - 1);
   assign last_idx = idx_q == IW'(NUM_CKEN - 1);
   assign nidx     = idx_q + IW'(1);
   assign pidx     = idx_q - IW'(1);
   // A stop seen during START is parked in pend_q and honoured on the first RAMP cycle.
   assign go_stop  = (seq_stop || (pend_q && state_q == S_RAMP)) &&
                     (state_q == S_RAMP || state_q == S_HOLD || state_q == S_RUN || state_q == S_DBG);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      cken_d  = cken_q;
      mask_d  = mask_q;
      gap_d   = gap_q;
      start_d = start_q;
      grst_d  = grst_q;
      dbg_d   = dbg_q;
      pend_d  = pend_q;
      if (go_stop) begin
         state_d = S_STOP;
         idx_d   = state_q == S_RAMP ? idx_q : IW'(NUM_CKEN - 1);
         cnt_d   = '0;
         grst_d  = 1'b0;
         dbg_d   = 1'b0;
         pend_d  = 1'b0;
         cken_d[state_q == S_RAMP ? idx_q : IW'(NUM_CKEN - 1)] = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (seq_start && !seq_stop) begin
                  state_d = S_START;
                  mask_d  = cken_mask;
                  gap_d   = gap_cnt;
                  start_d = 1'b1;
               end
            end
            S_START: begin
               state_d   = S_RAMP;
               pend_d    = seq_stop;
               idx_d     = '0;
               cnt_d     = '0;
               cken_d[0] = mask_q[0];
            end
            S_RAMP: begin
               if (!slot_end) begin
                  cnt_d = cnt_q + GAP_W'(1);
               end else if (last_idx) begin
                  state_d = S_HOLD;
                  hcnt_d  = '0;
               end else begin
                  idx_d        = nidx;
                  cnt_d        = '0;
                  cken_d[nidx] = mask_q[nidx];
               end
            end
            S_HOLD: begin
               if (hold_end) begin
                  state_d = S_RUN;
                  grst_d  = 1'b1;
                  dbg_d   = 1'b1;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
            S_RUN: begin
               if (dbg_init_req) begin
                  state_d = S_DBG;
                  dbg_d   = 1'b0;
                  hcnt_d  = '0;
               end
            end
            S_DBG: begin
               if (hold_end) begin
                  state_d = S_RUN;
                  dbg_d   = 1'b1;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
            S_STOP: begin
               if (!slot_end) begin
                  cnt_d = cnt_q + GAP_W'(1);
               end else if (idx_q == '0) begin
                  state_d = S_IDLE;
                  start_d = 1'b0;
               end else begin
                  idx_d        = pidx;
                  cnt_d        = '0;
                  cken_d[pidx] = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Status flags are decoded from the next state so they are registered alongside it.
   assign busy_d = state_d == S_START || state_d == S_RAMP || state_d == S_HOLD || state_d == S_STOP;
   assign done_d = state_d == S_RUN || state_d == S_DBG;

   always_ff @(posedge cmp_gclk or posedge cmp_rst) begin
      if (cmp_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         hcnt_q  <= '0;
         cken_q  <= '0;
         mask_q  <= '0;
         gap_q   <= '0;
         start_q <= 1'b0;
         grst_q  <= 1'b0;
         dbg_q   <= 1'b0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         cken_q  <= cken_d;
         mask_q  <= mask_d;
         gap_q   <= gap_d;
         start_q <= start_d;
         grst_q  <= grst_d;
         dbg_q   <= dbg_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign start_clk_cl     = start_q;
   assign cken_cg          = cken_q;
   assign cmp_grst_cl_l    = grst_q;
   assign cmp_dbginit_cl_l = dbg_q;
   assign seq_busy         = busy_q;
   assign seq_done         = done_q;
endmodule

// File: tb/tb_ctu_clsp_ckseq.sv
// tb_ctu_clsp_ckseq: directed bench for the clock-enable/reset sequencer.
module tb_ctu_clsp_ckseq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seq_start = 1'b0, seq_stop = 1'b0, dbg_init_req = 1'b0;
   logic [21:0] cken_mask = '0;
   logic [3:0]  gap_cnt = '0;
   logic        start_clk_cl, cmp_grst_cl_l, cmp_dbginit_cl_l, seq_busy, seq_done;
   logic [21:0] cken_cg;
   int          cyc = 0, passed = 0, total = 0, t0 = 0, t1 = 0;

   ctu_clsp_ckseq dut (
      .cmp_gclk(clk), .cmp_rst(rst), .seq_start(seq_start), .seq_stop(seq_stop),
      .dbg_init_req(dbg_init_req), .cken_mask(cken_mask), .gap_cnt(gap_cnt),
      .start_clk_cl(start_clk_cl), .cken_cg(cken_cg), .cmp_grst_cl_l(cmp_grst_cl_l),
      .cmp_dbginit_cl_l(cmp_dbginit_cl_l), .seq_busy(seq_busy), .seq_done(seq_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic zeros(input string tag);
      chk({tag, "_start"}, 32'(start_clk_cl), 0);
      chk({tag, "_cken"}, 32'(cken_cg), 0);
      chk({tag, "_grst"}, 32'(cmp_grst_cl_l), 0);
      chk({tag, "_dbg"}, 32'(cmp_dbginit_cl_l), 0);
      chk({tag, "_busy"}, 32'(seq_busy), 0);
      chk({tag, "_done"}, 32'(seq_done), 0);
   endtask

   task automatic pulse_start(input logic [21:0] m, input logic [3:0] g);
      cken_mask = m;
      gap_cnt   = g;
      seq_start = 1'b1;
      tick(1);
      seq_start = 1'b0;
      t0 = cyc;
   endtask

   task automatic pulse_stop();
      seq_stop = 1'b1;
      tick(1);
      seq_stop = 1'b0;
      t1 = cyc;
   endtask

   task automatic wait_grst(input int bound);
      for (int k = 0; k < bound && cmp_grst_cl_l !== 1'b1; k++) tick(1);
   endtask

   task automatic wait_clk_low(input int bound);
      for (int k = 0; k < bound && start_clk_cl !== 1'b0; k++) tick(1);
   endtask

   initial begin
      tick(2);
      zeros("reset");
      rst = 1'b0;
      tick(1);
      zeros("idle");

      // full ramp, gap 0
      pulse_start('1, 4'd0);
      chk("full_e0_start", 32'(start_clk_cl), 1);
      chk("full_e0_busy", 32'(seq_busy), 1);
      chk("full_e0_cken", 32'(cken_cg), 0);
      for (int i = 0; i < 22; i++) begin
         tick(1);
         chk($sformatf("full_bit%0d", i), 32'(cken_cg), 32'((64'd1 << (i + 1)) - 1));
      end
      wait_grst(200);
      chk("full_grst_time", 32'(cyc - t0), 39);
      chk("full_dbg_hi", 32'(cmp_dbginit_cl_l), 1);
      chk("full_done", 32'(seq_done), 1);
      chk("full_busy", 32'(seq_busy), 0);

      // debug init with a second request inside the window
      dbg_init_req = 1'b1;
      tick(1);
      dbg_init_req = 1'b0;
      t1 = cyc;
      chk("dbg_low", 32'(cmp_dbginit_cl_l), 0);
      chk("dbg_grst_hi", 32'(cmp_grst_cl_l), 1);
      chk("dbg_done", 32'(seq_done), 1);
      tick(4);
      dbg_init_req = 1'b1;
      tick(1);
      dbg_init_req = 1'b0;
      for (int k = 0; k < 100 && cmp_dbginit_cl_l !== 1'b1; k++) tick(1);
      chk("dbg_len", 32'(cyc - t1), 16);
      tick(3);
      chk("dbg_stays_hi", 32'(cmp_dbginit_cl_l), 1);
      chk("dbg_grst_after", 32'(cmp_grst_cl_l), 1);

      // start in RUN is ignored
      seq_start = 1'b1;
      tick(1);
      seq_start = 1'b0;
      tick(1);
      chk("run_start_ign_busy", 32'(seq_busy), 0);
      chk("run_start_ign_done", 32'(seq_done), 1);

      // stop from RUN, gap 0
      pulse_stop();
      chk("stop0_grst", 32'(cmp_grst_cl_l), 0);
      chk("stop0_dbg", 32'(cmp_dbginit_cl_l), 0);
      chk("stop0_cken", 32'(cken_cg), 32'h1fffff);
      wait_clk_low(200);
      chk("stop0_time", 32'(cyc - t1), 22);
      zeros("stop0_end");

      // sparse ramp with shadow-register check
      pulse_start(22'h000005, 4'd3);
      cken_mask = '1;
      gap_cnt   = 4'd0;
      for (int k = 0; k < 50 && cken_cg[0] !== 1'b1; k++) tick(1);
      chk("sparse_b0_time", 32'(cyc - t0), 1);
      t1 = cyc;
      for (int k = 0; k < 50 && cken_cg[2] !== 1'b1; k++) tick(1);
      chk("sparse_b2_gap", 32'(cyc - t1), 8);
      chk("sparse_b2_cken", 32'(cken_cg), 5);
      wait_grst(300);
      chk("sparse_grst_time", 32'(cyc - t0), 105);
      chk("sparse_final_cken", 32'(cken_cg), 5);
      pulse_stop();
      wait_clk_low(300);
      chk("sparse_stop_time", 32'(cyc - t1), 88);

      // gap 1 ramp then orderly stop
      pulse_start('1, 4'd1);
      wait_grst(300);
      chk("g1_grst_time", 32'(cyc - t0), 61);
      pulse_stop();
      chk("g1_stop_grst", 32'(cmp_grst_cl_l), 0);
      chk("g1_stop_dbg", 32'(cmp_dbginit_cl_l), 0);
      chk("g1_stop_cken0", 32'(cken_cg), 32'h1fffff);
      chk("g1_stop_busy", 32'(seq_busy), 1);
      tick(2);
      chk("g1_stop_cken2", 32'(cken_cg), 32'h0fffff);
      wait_clk_low(200);
      chk("g1_stop_time", 32'(cyc - t1), 44);
      zeros("g1_end");

      // stop during START is deferred to RAMP entry
      pulse_start('1, 4'd0);
      pulse_stop();
      chk("pend_ramp_cken", 32'(cken_cg), 1);
      tick(1);
      chk("pend_stop_cken", 32'(cken_cg), 0);
      chk("pend_stop_busy", 32'(seq_busy), 1);
      tick(1);
      zeros("pend_end");

      // abort mid-ramp at index 5
      pulse_start('1, 4'd0);
      tick(6);
      chk("abort_pre", 32'(cken_cg), 32'h3f);
      pulse_stop();
      chk("abort_s0", 32'(cken_cg), 32'h1f);
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk($sformatf("abort_s%0d", k), 32'(cken_cg), 32'((1 << (5 - k)) - 1));
      end
      tick(1);
      zeros("abort_end");

      // asynchronous reset during HOLD
      pulse_start('1, 4'd0);
      tick(28);
      chk("hold_busy", 32'(seq_busy), 1);
      chk("hold_grst", 32'(cmp_grst_cl_l), 0);
      chk("hold_cken", 32'(cken_cg), 32'h3fffff);
      #2 rst = 1'b1;
      #1 zeros("async_rst");
      #1 rst = 1'b0;
      tick(1);
      zeros("post_rst");

      // simultaneous start and stop in IDLE
      seq_start = 1'b1;
      seq_stop  = 1'b1;
      tick(1);
      seq_start = 1'b0;
      seq_stop  = 1'b0;
      zeros("both_e0");
      tick(3);
      zeros("both_e3");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
